// File: rtl/aer_event_controller.sv
// AER event controller: round-robin arbitration over NCH four-phase AER input
// links, single-cycle synaptic events, N-cycle time-reference and scheduler
// sweeps, virtual-event pushes with back-pressure, and illegal-event flagging.
module aer_event_controller #(
  parameter int unsigned N   = 256,
  parameter int unsigned M   = 8,
  parameter int unsigned SPW = 8,
  parameter int unsigned NCH = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NCH*(2*M+1)-1:0]           AERIN_ADDR,
  input  logic [NCH-1:0]                   AERIN_REQ,
  output logic [NCH-1:0]                   AERIN_ACK,
  input  logic                             SCHED_EMPTY,
  input  logic                             SCHED_FULL,
  input  logic [M+4:0]                     SCHED_DATA_OUT,
  input  logic                             AEROUT_CTRL_BUSY,
  output logic                             CTRL_SYN_CS,
  output logic [2*M-$clog2(SPW)-1:0]       CTRL_SYN_ADDR,
  output logic [SPW-1:0]                   CTRL_PRE_EN,
  output logic                             CTRL_NEUR_EVENT,
  output logic [M-1:0]                     CTRL_NEUR_ADDR,
  output logic                             CTRL_NEUR_TREF,
  output logic                             CTRL_NEUR_VIRT,
  output logic [4:0]                       CTRL_NEUR_PARAM,
  output logic                             CTRL_SCHED_PUSH,
  output logic                             CTRL_SCHED_POP,
  output logic [M-1:0]                     CTRL_SCHED_ADDR,
  output logic [4:0]                       CTRL_SCHED_PARAM,
  output logic                             CTRL_AEROUT_POP_NEUR,
  output logic                             CTRL_ILLEGAL,
  output logic                             CTRL_BUSY
);

  localparam int unsigned S        = $clog2(SPW);
  localparam int unsigned AW       = 2 * M + 1;
  localparam int unsigned WW       = M - S;
  localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [M-1:0] CNT_LAST = M'(N - 1);
  localparam logic [M-1:0] SUB_MASK = M'(SPW - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYN, ST_TREF_SWEEP, ST_PUSH, ST_ILL, ST_ACK, ST_POP_NEUR, ST_POP_VIRT
  } state_t;

  state_t         state, state_nxt;
  logic [M-1:0]   cnt;
  logic [CW-1:0]  rr, ch_q, gnt_idx;
  logic           gnt_vld, do_grant;
  logic [AW-1:0]  addr_q, gnt_addr;

  logic [M-1:0]   pre, post, head;
  logic [4:0]     head_param, virt_param;
  state_t         pop_state;

  // Event decode of a latched AER address.
  function automatic state_t decode(input logic [AW-1:0] a);
    state_t d;
    if (a[2*M])                d = ST_SYN;
    else if (&a[M-1:0])        d = ST_TREF_SWEEP;
    else if (a[2:0] == 3'b001) d = ST_PUSH;
    else                       d = ST_ILL;
    return d;
  endfunction

  assign pre        = addr_q[2*M-1:M];
  assign post       = addr_q[M-1:0];
  assign virt_param = addr_q[M-1:M-5];
  assign head       = SCHED_DATA_OUT[M-1:0];
  assign head_param = SCHED_DATA_OUT[M+4:M];
  assign pop_state  = (head_param != 5'd0) ? ST_POP_VIRT : ST_POP_NEUR;
  assign gnt_addr   = AERIN_ADDR[gnt_idx*AW +: AW];

  // Round-robin pick: first requesting channel at or after the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (!gnt_vld && AERIN_REQ[(int'(rr) + k) % int'(NCH)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'((int'(rr) + k) % int'(NCH));
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sweep counter, grant latch and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      rr     <= '0;
      ch_q   <= '0;
      addr_q <= '0;
    end else begin
      if (state == ST_TREF_SWEEP || state == ST_POP_NEUR) cnt <= cnt + M'(1);
      else if (state == ST_IDLE)                          cnt <= '0;
      if (do_grant) begin
        addr_q <= gnt_addr;
        ch_q   <= gnt_idx;
        rr     <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt            = state;
    do_grant             = 1'b0;
    AERIN_ACK            = '0;
    CTRL_SYN_CS          = 1'b0;
    CTRL_SYN_ADDR        = '0;
    CTRL_PRE_EN          = '0;
    CTRL_NEUR_EVENT      = 1'b0;
    CTRL_NEUR_ADDR       = '0;
    CTRL_NEUR_TREF       = 1'b0;
    CTRL_NEUR_VIRT       = 1'b0;
    CTRL_NEUR_PARAM      = '0;
    CTRL_SCHED_PUSH      = 1'b0;
    CTRL_SCHED_POP       = 1'b0;
    CTRL_SCHED_ADDR      = '0;
    CTRL_SCHED_PARAM     = '0;
    CTRL_AEROUT_POP_NEUR = 1'b0;
    CTRL_ILLEGAL         = 1'b0;
    CTRL_BUSY            = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (SCHED_FULL && !SCHED_EMPTY) begin
          state_nxt = pop_state;
        end else if (gnt_vld && !AEROUT_CTRL_BUSY) begin
          do_grant  = 1'b1;
          state_nxt = decode(gnt_addr);
        end else if (!SCHED_EMPTY) begin
          state_nxt = pop_state;
        end
      end
      ST_SYN: begin
        CTRL_SYN_CS     = 1'b1;
        CTRL_SYN_ADDR   = {pre, WW'(post >> S)};
        CTRL_PRE_EN     = SPW'(1) << (post & SUB_MASK);
        CTRL_NEUR_EVENT = 1'b1;
        CTRL_NEUR_ADDR  = post;
        state_nxt       = ST_ACK;
      end
      ST_TREF_SWEEP: begin
        CTRL_NEUR_EVENT = 1'b1;
        CTRL_NEUR_TREF  = 1'b1;
        CTRL_NEUR_ADDR  = cnt;
        if (cnt == CNT_LAST) state_nxt = ST_ACK;
      end
      ST_PUSH: begin
        if (!SCHED_FULL) begin
          CTRL_SCHED_PUSH  = 1'b1;
          CTRL_SCHED_ADDR  = pre;
          CTRL_SCHED_PARAM = virt_param;
          state_nxt        = ST_ACK;
        end
      end
      ST_ILL: begin
        CTRL_ILLEGAL = 1'b1;
        state_nxt    = ST_ACK;
      end
      ST_ACK: begin
        if (AERIN_REQ[ch_q]) AERIN_ACK[ch_q] = 1'b1;
        else                 state_nxt       = ST_IDLE;
      end
      ST_POP_NEUR: begin
        CTRL_NEUR_EVENT      = 1'b1;
        CTRL_NEUR_ADDR       = cnt;
        CTRL_PRE_EN          = SPW'(1) << (cnt & SUB_MASK);
        CTRL_SYN_CS          = ((cnt & SUB_MASK) == '0);
        CTRL_SYN_ADDR        = {head, WW'(cnt >> S)};
        CTRL_AEROUT_POP_NEUR = (cnt == head);
        if (cnt == CNT_LAST) begin
          CTRL_SCHED_POP = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end
      ST_POP_VIRT: begin
        CTRL_NEUR_EVENT = 1'b1;
        CTRL_NEUR_VIRT  = 1'b1;
        CTRL_NEUR_ADDR  = head;
        CTRL_NEUR_PARAM = head_param;
        CTRL_SCHED_POP  = 1'b1;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aer_event_controller.sv
// Directed self-checking bench for aer_event_controller (N=256, M=8, SPW=8, NCH=2).
module tb_aer_event_controller;

  logic        CLK, RST;
  logic [33:0] AERIN_ADDR;
  logic [1:0]  AERIN_REQ, AERIN_ACK;
  logic        SCHED_EMPTY, SCHED_FULL, AEROUT_CTRL_BUSY;
  logic [12:0] SCHED_DATA_OUT;
  logic        CTRL_SYN_CS;
  logic [12:0] CTRL_SYN_ADDR;
  logic [7:0]  CTRL_PRE_EN;
  logic        CTRL_NEUR_EVENT;
  logic [7:0]  CTRL_NEUR_ADDR;
  logic        CTRL_NEUR_TREF, CTRL_NEUR_VIRT;
  logic [4:0]  CTRL_NEUR_PARAM;
  logic        CTRL_SCHED_PUSH, CTRL_SCHED_POP;
  logic [7:0]  CTRL_SCHED_ADDR;
  logic [4:0]  CTRL_SCHED_PARAM;
  logic        CTRL_AEROUT_POP_NEUR, CTRL_ILLEGAL, CTRL_BUSY;

  logic [57:0] outs;
  int checks = 0;
  int errors = 0;

  assign outs = {AERIN_ACK, CTRL_SYN_CS, CTRL_SYN_ADDR, CTRL_PRE_EN, CTRL_NEUR_EVENT,
                 CTRL_NEUR_ADDR, CTRL_NEUR_TREF, CTRL_NEUR_VIRT, CTRL_NEUR_PARAM,
                 CTRL_SCHED_PUSH, CTRL_SCHED_POP, CTRL_SCHED_ADDR, CTRL_SCHED_PARAM,
                 CTRL_AEROUT_POP_NEUR, CTRL_ILLEGAL, CTRL_BUSY};

  aer_event_controller #(.N(256), .M(8), .SPW(8), .NCH(2)) dut (
    .CLK(CLK), .RST(RST),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .SCHED_EMPTY(SCHED_EMPTY), .SCHED_FULL(SCHED_FULL), .SCHED_DATA_OUT(SCHED_DATA_OUT),
    .AEROUT_CTRL_BUSY(AEROUT_CTRL_BUSY),
    .CTRL_SYN_CS(CTRL_SYN_CS), .CTRL_SYN_ADDR(CTRL_SYN_ADDR), .CTRL_PRE_EN(CTRL_PRE_EN),
    .CTRL_NEUR_EVENT(CTRL_NEUR_EVENT), .CTRL_NEUR_ADDR(CTRL_NEUR_ADDR),
    .CTRL_NEUR_TREF(CTRL_NEUR_TREF), .CTRL_NEUR_VIRT(CTRL_NEUR_VIRT),
    .CTRL_NEUR_PARAM(CTRL_NEUR_PARAM), .CTRL_SCHED_PUSH(CTRL_SCHED_PUSH),
    .CTRL_SCHED_POP(CTRL_SCHED_POP), .CTRL_SCHED_ADDR(CTRL_SCHED_ADDR),
    .CTRL_SCHED_PARAM(CTRL_SCHED_PARAM), .CTRL_AEROUT_POP_NEUR(CTRL_AEROUT_POP_NEUR),
    .CTRL_ILLEGAL(CTRL_ILLEGAL), .CTRL_BUSY(CTRL_BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (outs !== 58'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
    RST = 1'b0;
    tick();
    checks++;
    if (outs !== 58'd0) begin errors++; $display("FAIL idle_outs: got %h want 0", outs); end
  endtask

  task automatic test_syn();
    AERIN_ADDR[16:0] = 17'h10523;
    AERIN_REQ = 2'b01;
    #1;
    checks++;
    if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL syn_idle_busy: got %b want 0", CTRL_BUSY); end
    tick();
    checks++;
    if ({CTRL_SYN_CS, CTRL_SYN_ADDR, CTRL_PRE_EN, CTRL_NEUR_EVENT, CTRL_NEUR_ADDR, CTRL_ILLEGAL, AERIN_ACK}
        !== {1'b1, 13'h0A4, 8'h08, 1'b1, 8'h23, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL syn_exec: cs=%b addr=%h pre=%h ev=%b na=%h ill=%b ack=%b want cs=1 addr=0a4 pre=08 ev=1 na=23 ill=0 ack=00",
               CTRL_SYN_CS, CTRL_SYN_ADDR, CTRL_PRE_EN, CTRL_NEUR_EVENT, CTRL_NEUR_ADDR, CTRL_ILLEGAL, AERIN_ACK);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (AERIN_ACK !== 2'b01 || CTRL_SYN_CS !== 1'b0) begin
        errors++; $display("FAIL syn_ack_%0d: ack=%b cs=%b want ack=01 cs=0", k, AERIN_ACK, CTRL_SYN_CS);
      end
    end
    AERIN_REQ = 2'b00;
    #1;
    checks++;
    if (AERIN_ACK !== 2'b00 || CTRL_BUSY !== 1'b1) begin
      errors++; $display("FAIL syn_ack_release: ack=%b busy=%b want ack=00 busy=1", AERIN_ACK, CTRL_BUSY);
    end
    tick();
    checks++;
    if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL syn_back_idle: busy=%b want 0", CTRL_BUSY); end
  endtask

  task automatic test_tref();
    AERIN_ADDR[33:17] = 17'h000FF;
    AERIN_REQ = 2'b10;
    tick();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if ({CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_ADDR, AERIN_ACK} !== {1'b1, 1'b1, 8'(i), 2'b00}) begin
        errors++;
        $display("FAIL tref_sweep_%0d: ev=%b tref=%b na=%h ack=%b want ev=1 tref=1 na=%h ack=00",
                 i, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_ADDR, AERIN_ACK, 8'(i));
      end
      tick();
    end
    checks++;
    if (AERIN_ACK !== 2'b10 || CTRL_NEUR_TREF !== 1'b0) begin
      errors++; $display("FAIL tref_ack: ack=%b tref=%b want ack=10 tref=0", AERIN_ACK, CTRL_NEUR_TREF);
    end
    AERIN_REQ = 2'b00;
    #1;
    checks++;
    if (AERIN_ACK !== 2'b00) begin errors++; $display("FAIL tref_ack_release: ack=%b want 00", AERIN_ACK); end
    tick();
    checks++;
    if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL tref_back_idle: busy=%b want 0", CTRL_BUSY); end
  endtask

  task automatic test_push();
    SCHED_DATA_OUT = 13'h307;
    SCHED_EMPTY = 1'b0;
    SCHED_FULL = 1'b1;
    AERIN_ADDR[16:0] = 17'h01229;
    AERIN_REQ = 2'b01;
    tick();
    checks++;
    if ({CTRL_NEUR_EVENT, CTRL_NEUR_VIRT, CTRL_NEUR_ADDR, CTRL_NEUR_PARAM, CTRL_SCHED_POP, CTRL_SCHED_PUSH}
        !== {1'b1, 1'b1, 8'h07, 5'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drain_pop_virt: ev=%b virt=%b na=%h par=%0d pop=%b push=%b want 1 1 07 3 1 0",
               CTRL_NEUR_EVENT, CTRL_NEUR_VIRT, CTRL_NEUR_ADDR, CTRL_NEUR_PARAM, CTRL_SCHED_POP, CTRL_SCHED_PUSH);
    end
    SCHED_EMPTY = 1'b1;
    tick();
    checks++;
    if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL push_gap_idle: busy=%b want 0", CTRL_BUSY); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (CTRL_SCHED_PUSH !== 1'b0 || CTRL_BUSY !== 1'b1 || AERIN_ACK !== 2'b00) begin
        errors++; $display("FAIL push_stall_%0d: push=%b busy=%b ack=%b want 0 1 00", k, CTRL_SCHED_PUSH, CTRL_BUSY, AERIN_ACK);
      end
      if (k < 3) tick();
    end
    SCHED_FULL = 1'b0;
    #1;
    checks++;
    if ({CTRL_SCHED_PUSH, CTRL_SCHED_ADDR, CTRL_SCHED_PARAM} !== {1'b1, 8'h12, 5'd5}) begin
      errors++;
      $display("FAIL push_issue: push=%b addr=%h par=%0d want 1 12 5", CTRL_SCHED_PUSH, CTRL_SCHED_ADDR, CTRL_SCHED_PARAM);
    end
    tick();
    checks++;
    if (AERIN_ACK !== 2'b01 || CTRL_SCHED_PUSH !== 1'b0) begin
      errors++; $display("FAIL push_ack: ack=%b push=%b want 01 0", AERIN_ACK, CTRL_SCHED_PUSH);
    end
    AERIN_REQ = 2'b00;
    tick();
  endtask

  task automatic test_illegal();
    AERIN_ADDR[33:17] = 17'h00002;
    AERIN_REQ = 2'b10;
    tick();
    checks++;
    if (CTRL_ILLEGAL !== 1'b1 || CTRL_NEUR_EVENT !== 1'b0 || AERIN_ACK !== 2'b00) begin
      errors++; $display("FAIL ill_pulse: ill=%b ev=%b ack=%b want 1 0 00", CTRL_ILLEGAL, CTRL_NEUR_EVENT, AERIN_ACK);
    end
    tick();
    checks++;
    if (AERIN_ACK !== 2'b10 || CTRL_ILLEGAL !== 1'b0) begin
      errors++; $display("FAIL ill_ack: ack=%b ill=%b want 10 0", AERIN_ACK, CTRL_ILLEGAL);
    end
    AERIN_REQ = 2'b00;
    tick();
  endtask

  task automatic test_pop_neur();
    int cs_cnt = 0, ap_cnt = 0, pop_cnt = 0;
    logic [12:0] exp_sa;
    SCHED_DATA_OUT = 13'h040;
    SCHED_EMPTY = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      exp_sa = 13'((32'h40 << 5) | (i >> 3));
      if (CTRL_SYN_CS === 1'b1) cs_cnt++;
      if (CTRL_AEROUT_POP_NEUR === 1'b1) ap_cnt++;
      if (CTRL_SCHED_POP === 1'b1) pop_cnt++;
      checks++;
      if ({CTRL_NEUR_EVENT, CTRL_NEUR_ADDR, CTRL_PRE_EN} !== {1'b1, 8'(i), 8'(1 << (i % 8))}) begin
        errors++;
        $display("FAIL popn_neur_%0d: ev=%b na=%h pre=%h want 1 %h %h", i, CTRL_NEUR_EVENT, CTRL_NEUR_ADDR, CTRL_PRE_EN,
                 8'(i), 8'(1 << (i % 8)));
      end
      checks++;
      if ({CTRL_SYN_CS, CTRL_AEROUT_POP_NEUR, CTRL_SCHED_POP} !== {(i % 8) == 0, i == 64, i == 255}) begin
        errors++;
        $display("FAIL popn_strobes_%0d: cs=%b aer=%b pop=%b want %b %b %b", i, CTRL_SYN_CS, CTRL_AEROUT_POP_NEUR,
                 CTRL_SCHED_POP, (i % 8) == 0, i == 64, i == 255);
      end
      if ((i % 8) == 0) begin
        checks++;
        if (CTRL_SYN_ADDR !== exp_sa) begin
          errors++; $display("FAIL popn_synaddr_%0d: got %h want %h", i, CTRL_SYN_ADDR, exp_sa);
        end
      end
      if (i == 255) SCHED_EMPTY = 1'b1;
      tick();
    end
    checks++;
    if (cs_cnt != 32 || ap_cnt != 1 || pop_cnt != 1) begin
      errors++; $display("FAIL popn_totals: cs=%0d aer=%0d pop=%0d want 32 1 1", cs_cnt, ap_cnt, pop_cnt);
    end
    checks++;
    if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL popn_back_idle: busy=%b want 0", CTRL_BUSY); end
  endtask

  task automatic test_aerout_busy();
    AERIN_ADDR[16:0] = 17'h10523;
    AEROUT_CTRL_BUSY = 1'b1;
    AERIN_REQ = 2'b01;
    tick();
    tick();
    checks++;
    if (CTRL_BUSY !== 1'b0 || CTRL_SYN_CS !== 1'b0) begin
      errors++; $display("FAIL aerbusy_block: busy=%b cs=%b want 0 0", CTRL_BUSY, CTRL_SYN_CS);
    end
    SCHED_DATA_OUT = 13'h307;
    SCHED_EMPTY = 1'b0;
    tick();
    checks++;
    if (CTRL_SCHED_POP !== 1'b1 || CTRL_NEUR_VIRT !== 1'b1) begin
      errors++; $display("FAIL aerbusy_sched: pop=%b virt=%b want 1 1", CTRL_SCHED_POP, CTRL_NEUR_VIRT);
    end
    SCHED_EMPTY = 1'b1;
    AERIN_REQ = 2'b00;
    AEROUT_CTRL_BUSY = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int ex;
    AERIN_ADDR[16:0]  = 17'h10523;
    AERIN_ADDR[33:17] = 17'h10111;
    AERIN_REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ex = k % 2;
      tick();
      checks++;
      if (CTRL_NEUR_ADDR !== ((ex == 1) ? 8'h11 : 8'h23) || CTRL_SYN_CS !== 1'b1) begin
        errors++; $display("FAIL rr_grant_%0d: na=%h cs=%b want %h 1", k, CTRL_NEUR_ADDR, CTRL_SYN_CS,
                           (ex == 1) ? 8'h11 : 8'h23);
      end
      tick();
      checks++;
      if (AERIN_ACK !== ((ex == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_ack_%0d: ack=%b want %b", k, AERIN_ACK, (ex == 1) ? 2'b10 : 2'b01);
      end
      AERIN_REQ[ex] = 1'b0;
      #1;
      checks++;
      if (AERIN_ACK !== 2'b00) begin errors++; $display("FAIL rr_release_%0d: ack=%b want 00", k, AERIN_ACK); end
      tick();
      checks++;
      if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL rr_idle_gap_%0d: busy=%b want 0", k, CTRL_BUSY); end
      AERIN_REQ[ex] = 1'b1;
    end
    AERIN_REQ = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    SCHED_DATA_OUT = 13'h040;
    SCHED_EMPTY = 1'b0;
    tick();
    repeat (100) tick();
    checks++;
    if (CTRL_NEUR_ADDR !== 8'd100) begin errors++; $display("FAIL rst_sweep_pos: na=%h want 64", CTRL_NEUR_ADDR); end
    RST = 1'b1;
    #1;
    checks++;
    if (outs !== 58'd0) begin errors++; $display("FAIL rst_mid_outs: got %h want 0", outs); end
    tick();
    checks++;
    if (outs !== 58'd0) begin errors++; $display("FAIL rst_hold_outs: got %h want 0", outs); end
    SCHED_EMPTY = 1'b1;
    RST = 1'b0;
    tick();
    checks++;
    if (CTRL_BUSY !== 1'b0 || CTRL_SCHED_POP !== 1'b0) begin
      errors++; $display("FAIL rst_resume_idle: busy=%b pop=%b want 0 0", CTRL_BUSY, CTRL_SCHED_POP);
    end
    AERIN_ADDR[16:0] = 17'h10523;
    AERIN_REQ = 2'b01;
    tick();
    checks++;
    if (CTRL_SYN_CS !== 1'b1 || CTRL_NEUR_ADDR !== 8'h23) begin
      errors++; $display("FAIL rst_resume_syn: cs=%b na=%h want 1 23", CTRL_SYN_CS, CTRL_NEUR_ADDR);
    end
    tick();
    checks++;
    if (AERIN_ACK !== 2'b01) begin errors++; $display("FAIL rst_resume_ack: ack=%b want 01", AERIN_ACK); end
    AERIN_REQ = 2'b00;
    tick();
    checks++;
    if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL rst_resume_done: busy=%b want 0", CTRL_BUSY); end
  endtask

  initial begin
    RST = 1'b1;
    AERIN_ADDR = '0;
    AERIN_REQ = '0;
    SCHED_EMPTY = 1'b1;
    SCHED_FULL = 1'b0;
    SCHED_DATA_OUT = '0;
    AEROUT_CTRL_BUSY = 1'b0;
    test_reset();
    test_syn();
    test_tref();
    test_push();
    test_illegal();
    test_pop_neur();
    test_aerout_busy();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
